// File: rtl/dna_stream_gen_if.sv
// -----------------------------------------------------------------------------
// dna_stream_gen_if
// Character stream handshake between the DNA base generator and its consumer.
//   valid : producer holds a character on out
//   ready : consumer accepts the current character
//   out   : 8-bit ASCII base
// A character transfers on a rising clock edge where valid && ready.
// -----------------------------------------------------------------------------
interface dna_stream_gen_if;
    logic       valid;
    logic       ready;
    logic [7:0] out;

    modport master (output valid, output out, input ready);
    modport slave  (input valid, input out, output ready);
endinterface

// File: rtl/dna_stream_gen.sv
// -----------------------------------------------------------------------------
// dna_stream_gen
// Source of a framed DNA character stream. Each frame is LEN characters of
// "C"/"G" filler taken from a 16-bit LFSR. On request the 8-character motif
// "ATATGCGA" is embedded, at most MAX_MOTIF times per frame. Because the filler
// alphabet holds neither "A" nor "T", no motif or motif prefix can appear
// except where one was injected.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-high reset
//   start   begin a frame (honoured only when idle or done)
//   inject  single-cycle request for one motif
//   stream  handshake bundle (valid/out driven, ready sampled)
//   busy    frame in progress (filler or motif)
//   done    frame finished
//   cnt     motifs fully emitted in the current frame
//   drop    sticky: an inject request was discarded in this frame
//   seed    LFSR load value (only with DNA_STREAM_GEN_SEED_EN)
//
// Build option: define DNA_STREAM_GEN_SEED_EN to add the seed port; the
// LFSR then loads seed on start instead of the SEED parameter.
// -----------------------------------------------------------------------------
module dna_stream_gen #(
    parameter int unsigned LEN       = 64,
    parameter int unsigned MAX_MOTIF = 3,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             inject,
    dna_stream_gen_if.master stream,
    output logic             busy,
    output logic             done,
    output logic [4:0]       cnt,
    output logic             drop
`ifdef DNA_STREAM_GEN_SEED_EN
    ,
    input  logic [15:0]      seed
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_MOTIF = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [7:0]  CH_A       = 8'h41;
    localparam logic [7:0]  CH_C       = 8'h43;
    localparam logic [7:0]  CH_G       = 8'h47;
    localparam logic [7:0]  CH_T       = 8'h54;
    localparam logic [15:0] DEF_SEED   = 16'hACE1;
    localparam logic [15:0] RESET_SEED = (SEED == 16'h0000) ? DEF_SEED : SEED;
    localparam logic [16:0] LEN_W      = 17'(LEN);
    localparam logic [5:0]  MAX_W      = 6'(MAX_MOTIF);

    // Fibonacci step, taps 16,14,13,11, shifting left with feedback into bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [7:0] filler_char(input logic b);
        logic [7:0] ch;
        if (b) begin
            ch = CH_G;
        end else begin
            ch = CH_C;
        end
        return ch;
    endfunction

    function automatic logic [7:0] motif_char(input logic [2:0] i);
        logic [7:0] ch;
        case (i)
            3'd0:    ch = CH_A;
            3'd1:    ch = CH_T;
            3'd2:    ch = CH_A;
            3'd3:    ch = CH_T;
            3'd4:    ch = CH_G;
            3'd5:    ch = CH_C;
            3'd6:    ch = CH_G;
            3'd7:    ch = CH_A;
            default: ch = CH_A;
        endcase
        return ch;
    endfunction

    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        logic [15:0] r;
        if (s == 16'h0000) begin
            r = DEF_SEED;
        end else begin
            r = s;
        end
        return r;
    endfunction

    state_e      state_q,   state_d;
    logic [15:0] lfsr_q,    lfsr_d;
    logic [15:0] pos_q,     pos_d;
    logic [2:0]  idx_q,     idx_d;
    logic        pending_q, pending_d;
    logic        valid_q,   valid_d;
    logic [7:0]  out_q,     out_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;
    logic [4:0]  cnt_q,     cnt_d;
    logic        drop_q,    drop_d;

    logic        xfer_s;
    logic        in_frame_s;
    logic [5:0]  budget_used_s;
    logic        inj_ok_s;
    logic        decide_s;
    logic        pend_eff_s;
    logic [15:0] pos_n_s;
    logic [16:0] remain_s;
    logic [15:0] load_seed_s;

`ifdef DNA_STREAM_GEN_SEED_EN
    assign load_seed_s = seed_fix(seed);
`else
    assign load_seed_s = seed_fix(SEED);
`endif

    // Next-state, next-output and inject bookkeeping for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        pos_d     = pos_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        valid_d   = valid_q;
        out_d     = out_q;
        busy_d    = busy_q;
        done_d    = done_q;
        cnt_d     = cnt_q;
        drop_d    = drop_q;
        decide_s  = 1'b0;

        xfer_s     = valid_q && stream.ready;
        in_frame_s = (state_q == S_FILL) || (state_q == S_MOTIF);
        pos_n_s    = pos_q + 16'd1;
        remain_s   = LEN_W - {1'b0, pos_n_s};
        // A motif being emitted still counts against the per-frame budget.
        budget_used_s = {1'b0, cnt_q} + {5'b00000, (state_q == S_MOTIF)};
        inj_ok_s      = inject && in_frame_s && !pending_q && (budget_used_s < MAX_W);

        if (inject && in_frame_s && !inj_ok_s) begin
            drop_d = 1'b1;
        end else begin
            drop_d = drop_q;
        end
        pending_d  = pending_q | inj_ok_s;
        // A same-cycle request is already visible to this cycle's decision.
        pend_eff_s = pending_q | inj_ok_s;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_FILL;
                    lfsr_d    = load_seed_s;
                    pos_d     = 16'd0;
                    idx_d     = 3'd0;
                    cnt_d     = 5'd0;
                    pending_d = 1'b0;
                    drop_d    = 1'b0;
                    valid_d   = 1'b1;
                    out_d     = filler_char(load_seed_s[0]);
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_FILL: begin
                if (xfer_s) begin
                    lfsr_d   = lfsr_step(lfsr_q);
                    pos_d    = pos_n_s;
                    decide_s = 1'b1;
                end else begin
                    lfsr_d = lfsr_q;
                end
            end
            S_MOTIF: begin
                if (xfer_s) begin
                    pos_d = pos_n_s;
                    if (idx_q == 3'd7) begin
                        cnt_d    = cnt_q + 5'd1;
                        decide_s = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        out_d = motif_char(idx_q + 3'd1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase

        // Choose what follows a filler character or the last motif character.
        if (decide_s) begin
            if ({1'b0, pos_n_s} == LEN_W) begin
                state_d   = S_DONE;
                valid_d   = 1'b0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                pending_d = 1'b0;
                if (pend_eff_s) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_d;
                end
            end else if (pend_eff_s && (remain_s >= 17'd8)) begin
                state_d   = S_MOTIF;
                idx_d     = 3'd0;
                out_d     = motif_char(3'd0);
                pending_d = 1'b0;
            end else if (pend_eff_s) begin
                // Too close to the frame end: motifs are never truncated.
                state_d   = S_FILL;
                out_d     = filler_char(lfsr_d[0]);
                pending_d = 1'b0;
                drop_d    = 1'b1;
            end else begin
                state_d = S_FILL;
                out_d   = filler_char(lfsr_d[0]);
            end
        end else begin
            state_d = state_d;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            lfsr_q    <= RESET_SEED;
            pos_q     <= 16'd0;
            idx_q     <= 3'd0;
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
            out_q     <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= 5'd0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            pos_q     <= pos_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
        end
    end

    assign stream.valid = valid_q;
    assign stream.out   = out_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cnt          = cnt_q;
    assign drop         = drop_q;

endmodule

// File: tb/tb_dna_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_dna_stream_gen
// Two generators share the clock: index 0 has LEN=16, index 1 has LEN=64,
// both MAX_MOTIF=3 and seed 16'hACE1. Before each frame the expected
// character sequence is pushed into that generator's queue; a negedge
// monitor compares every presented character against the queue head and pops
// it when the character transfers.
// -----------------------------------------------------------------------------
module tb_dna_stream_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst_s;
    logic [1:0]      start_s;
    logic [1:0]      inject_s;
    logic [1:0]      ready_s;
    logic [1:0]      valid_w;
    logic [1:0]      busy_w;
    logic [1:0]      done_w;
    logic [1:0]      drop_w;
    logic [1:0][4:0] cnt_w;
    logic [1:0][7:0] out_w;

    dna_stream_gen_if if16 ();
    dna_stream_gen_if if64 ();

    assign if16.ready = ready_s[0];
    assign if64.ready = ready_s[1];
    assign valid_w[0] = if16.valid;
    assign valid_w[1] = if64.valid;
    assign out_w[0]   = if16.out;
    assign out_w[1]   = if64.out;

    dna_stream_gen #(.LEN(16), .MAX_MOTIF(3), .SEED(16'hACE1)) u_len16 (
        .clk    (clk),
        .reset  (rst_s[0]),
        .start  (start_s[0]),
        .inject (inject_s[0]),
        .stream (if16),
        .busy   (busy_w[0]),
        .done   (done_w[0]),
        .cnt    (cnt_w[0]),
        .drop   (drop_w[0])
`ifdef DNA_STREAM_GEN_SEED_EN
        ,
        .seed   (16'hACE1)
`endif
    );

    dna_stream_gen #(.LEN(64), .MAX_MOTIF(3), .SEED(16'hACE1)) u_len64 (
        .clk    (clk),
        .reset  (rst_s[1]),
        .start  (start_s[1]),
        .inject (inject_s[1]),
        .stream (if64),
        .busy   (busy_w[1]),
        .done   (done_w[1]),
        .cnt    (cnt_w[1]),
        .drop   (drop_w[1])
`ifdef DNA_STREAM_GEN_SEED_EN
        ,
        .seed   (16'hACE1)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [7:0] qfront(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int d);
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    // Expected frame: reference LFSR for filler, fixed motif text at the
    // hand-computed start positions (negative = none).
    task automatic push_frame(input int d, input int len, input int m0, input int m1, input int m2);
        logic [15:0] l;
        logic [63:0] mv;
        logic [7:0]  ch;
        int          k;
        l  = 16'hACE1;
        mv = 64'h4154_4154_4743_4741; // "ATATGCGA"
        for (int p = 0; p < len; p++) begin
            k = -1;
            if (m0 >= 0 && p >= m0 && p < m0 + 8)      k = p - m0;
            else if (m1 >= 0 && p >= m1 && p < m1 + 8) k = p - m1;
            else if (m2 >= 0 && p >= m2 && p < m2 + 8) k = p - m2;
            if (k >= 0) begin
                ch = mv[63 - 8*k -: 8];
            end else begin
                ch = l[0] ? 8'h47 : 8'h43;
                l  = {l[14:0], ^(l & 16'hB400)};
            end
            if (d == 0) q0.push_back(ch);
            else        q1.push_back(ch);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every presented character must match the queue head.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (valid_w[d] === 1'b1) begin
                if (qsize(d) == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_char dut=%0d actual=%0h required=none", d, out_w[d]);
                end else begin
                    check(ready_s[d] ? "xfer_char" : "stall_hold", 32'(out_w[d]), 32'(qfront(d)));
                    if (ready_s[d]) qpop(d);
                end
            end
        end
    end

    // Run one frame. Injects are listed by the edge index (start sampled at
    // edge 1) at which they are sampled; -1 means unused.
    task automatic frame(input string tag, input int d, input int len,
                         input int i0, input int i1, input int i2, input int i3,
                         input int m0, input int m1, input int m2,
                         input bit stall, input int exp_cnt, input bit exp_drop);
        int c;
        bit seen;
        push_frame(d, len, m0, m1, m2);
        start_s[d] = 1'b1;
        tick();
        start_s[d] = 1'b0;
        check({tag, "_valid_lat1"}, 32'(valid_w[d]), 32'd1);
        check({tag, "_busy"}, 32'(busy_w[d]), 32'd1);
        c    = 1;
        seen = 1'b0;
        while (c < 600 && !seen) begin
            if (done_w[d] === 1'b1) begin
                seen = 1'b1;
            end else begin
                inject_s[d] = (c + 1 == i0) || (c + 1 == i1) || (c + 1 == i2) || (c + 1 == i3);
                ready_s[d]  = (!stall || c + 1 <= 2) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
                tick();
                c++;
            end
        end
        inject_s[d] = 1'b0;
        ready_s[d]  = 1'b1;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (!stall) check({tag, "_done_cycle"}, 32'(c), 32'(len + 1));
        check({tag, "_cnt"}, 32'(cnt_w[d]), 32'(exp_cnt));
        check({tag, "_drop"}, 32'(drop_w[d]), 32'(exp_drop));
        check({tag, "_busy_end"}, 32'(busy_w[d]), 32'd0);
        check({tag, "_valid_end"}, 32'(valid_w[d]), 32'd0);
        check({tag, "_all_chars"}, 32'(qsize(d)), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_s    = 2'b11;
        start_s  = 2'b00;
        inject_s = 2'b00;
        ready_s  = 2'b11;
        #2;
        for (int d = 0; d < 2; d++) begin
            check("rst_valid", 32'(valid_w[d]), 32'd0);
            check("rst_out",   32'(out_w[d]),   32'd0);
            check("rst_busy",  32'(busy_w[d]),  32'd0);
            check("rst_done",  32'(done_w[d]),  32'd0);
            check("rst_cnt",   32'(cnt_w[d]),   32'd0);
            check("rst_drop",  32'(drop_w[d]),  32'd0);
        end
        tick();
        rst_s = 2'b00;
        tick();

        // Plain filler frame.
        frame("plain16", 0, 16, -1, -1, -1, -1, -1, -1, -1, 1'b0, 0, 1'b0);
        // Inject sampled with the first transfer: motif starts at pos 1.
        frame("inj64", 1, 64, 2, -1, -1, -1, 1, -1, -1, 1'b0, 1, 1'b0);
        // Same motif with ready stalls 1,0,0,1 through the frame.
        frame("stall64", 1, 64, 2, -1, -1, -1, 1, -1, -1, 1'b1, 1, 1'b0);
        // Four requests 12 cycles apart; the fourth exceeds the budget.
        frame("budget64", 1, 64, 2, 14, 26, 38, 1, 13, 25, 1'b0, 3, 1'b1);
        // Request at pos 10 of 16: cannot fit, discarded.
        frame("tail16", 0, 16, 12, -1, -1, -1, -1, -1, -1, 1'b0, 0, 1'b1);

        // Reset in the middle of a motif.
        push_frame(1, 64, 1, -1, -1);
        start_s[1] = 1'b1;
        tick();
        start_s[1]  = 1'b0;
        inject_s[1] = 1'b1;
        tick();
        inject_s[1] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("pre_rst_idx4_char", 32'(out_w[1]), 32'h47);
        check("pre_rst_busy", 32'(busy_w[1]), 32'd1);
        rst_s[1] = 1'b1;
        #1;
        check("mid_rst_valid", 32'(valid_w[1]), 32'd0);
        check("mid_rst_busy",  32'(busy_w[1]),  32'd0);
        check("mid_rst_cnt",   32'(cnt_w[1]),   32'd0);
        check("mid_rst_out",   32'(out_w[1]),   32'd0);
        check("mid_rst_done",  32'(done_w[1]),  32'd0);
        q1.delete();
        tick();
        rst_s[1] = 1'b0;
        tick();
        frame("after_rst64", 1, 64, -1, -1, -1, -1, -1, -1, -1, 1'b0, 0, 1'b0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dna_stream_gen.md
Name: dna_stream_gen

Overview:
- Source end of the DNA character stream: emits an 8-bit ASCII base sequence ("A","C","G","T") one character per handshake.
- Can embed the 8-character hazard motif "ATATGCGA" on request, so detector-side logic can be driven and checked against a known number of motif occurrences.
- Filler bases come from an LFSR and are limited to "C"/"G", so no motif, or motif prefix, can appear outside an injected one.

Parameters:
- LEN, 64: characters per frame; legal range 8..65535.
- MAX_MOTIF, 3: maximum motifs injected per frame; legal range 1..31.
- SEED, 16'hACE1: LFSR seed loaded on start; a value of 0 is replaced by 16'hACE1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a frame; honoured only in IDLE or DONE.
- inject  input  1  request one motif; single-cycle pulse.
- ready  input  1  downstream accepts the current character.
- valid  output  1  out holds a character.
- out  output  8  ASCII base.
- busy  output  1  high in FILL or MOTIF.
- done  output  1  high in DONE.
- cnt  output  5  motifs fully emitted in the current frame.
- drop  output  1  sticky flag: an inject request was discarded in this frame.

Behaviour:
- Reset values: state=IDLE, valid=0, out=8'h00, busy=0, done=0, cnt=0, drop=0, pending=0, pos=0, LFSR=SEED.
- Reset takes effect immediately, including mid-frame or mid-motif. The partial frame is abandoned and nothing resumes.
- Transfer rule: a character transfers on a rising clk edge where valid && ready.
  - While valid=1 and ready=0, out must hold stable.
  - valid never drops without a transfer, except on reset.
- pos is a 16-bit count of characters transferred in the frame.
- States:
  - IDLE, or DONE, with start=1:
    - load the LFSR with SEED, clear pos, cnt, pending and drop;
    - go to FILL.
    - valid rises on the next cycle, with the first character presented. Latency is 1 cycle from start to valid.
  - FILL:
    - out = "C" (8'h43) when LFSR[0]=0, "G" (8'h47) when LFSR[0]=1.
    - On transfer: the LFSR steps once (Fibonacci, taps 16,14,13,11, shifting left, feedback into bit 0), and pos increments.
    - Choosing the next character after a transfer:
      - pos==LEN goes to DONE;
      - otherwise, pending=1 and LEN-pos>=8 goes to MOTIF with index 0 and clears pending;
      - otherwise the next character is filler.
  - MOTIF:
    - out = "ATATGCGA"[idx], idx 0..7. The LFSR does not step.
    - On the transfer of idx 7, cnt increments. The next character follows the FILL rules: DONE, another pending motif, or filler.
  - DONE: valid=0, done=1. Holds until start or reset.
- inject handling:
  - Sampled every cycle. If in FILL or MOTIF, cnt plus motifs in flight or pending is below MAX_MOTIF, and pending=0, then pending is set.
  - If pending is already 1, or the budget is exhausted, the request is ignored and drop is set.
  - inject in IDLE or DONE is ignored without setting drop.
- Frame tail:
  - A pending motif that cannot fit (LEN-pos<8) is discarded at that decision point and drop is set.
  - Motifs are never truncated.
- Simultaneous events:
  - inject in the same cycle as the transfer that decides the next character counts as pending for that decision.
  - start while busy is ignored.
- Motif boundaries: back-to-back motifs are allowed. Filler is only "C"/"G", so each injected motif is detectable in isolation.

Optional Feature:
- Macro: DNA_STREAM_GEN_SEED_EN.
- Defined: adds the port seed (input, 16 bits). The LFSR loads seed on start, with 0 replaced by 16'hACE1. The SEED parameter is unused.
- Undefined: no seed port; the LFSR loads the SEED parameter.

Test Plan:
- LEN=16, ready=1, start pulse, no inject: 16 transfers, all "C"/"G" matching the reference LFSR model. done rises the cycle after the 16th transfer. cnt=0, drop=0.
- LEN=64, inject one cycle after start, ready=1: the character at pos 1 or 2 begins "ATATGCGA". cnt=1 after the 8 motif characters. Total transfers=64.
- ready toggled 1,0,0,1 repeatedly during a motif: out holds each character through the stall cycles, and the sequence is still exactly "ATATGCGA". cnt increments once.
- MAX_MOTIF=3, four inject pulses spaced 12 cycles apart: cnt ends at 3, drop=1. The frame contains exactly 3 motifs.
- LEN=16, inject issued when pos=10: motif discarded, drop=1, cnt=0. Frame ends with 16 filler characters.
- reset asserted at motif idx 4: valid, cnt, busy and out go to 0 immediately. After a new start, the first character is filler derived from SEED.
